// File: rtl/modulud_pkg.sv
// modulud_pkg: shared types and constants for the modulud remainder unit.
package modulud_pkg;

    // Default operand/result width.
    localparam int unsigned MODULUD_WIDTH = 16;

    // Iteration counter width at the default operand width.
    localparam int unsigned MODULUD_CNT_W = $clog2(MODULUD_WIDTH);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Counter width for an arbitrary width, kept at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/modulud_step.sv
// modulud_step: one combinational restoring shift-subtract iteration.
module modulud_step
    import modulud_pkg::*;
#(
    parameter int unsigned WIDTH = MODULUD_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Compare and subtract one bit wider so a divisor with its MSB set cannot overflow.
    always_comb begin
        trial    = {rem, din};
        diff     = trial - {1'b0, divisor};
        q_bit    = (trial >= {1'b0, divisor});
        rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/modulud.sv
// modulud: sequential unsigned remainder, one quotient bit per clock.
// Optional feature macro: MODULUD_EARLY_EXIT_EN (skip the iterations when dividend < divisor).
module modulud
    import modulud_pkg::*;
#(
    parameter int unsigned WIDTH = MODULUD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             short_q, short_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             start_short;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

`ifdef MODULUD_EARLY_EXIT_EN
    assign start_short = (divisor == '0) || (dividend < divisor);
`else
    assign start_short = (divisor == '0);
`endif

    modulud_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .din      (dividend_q[WIDTH-1]),
        .divisor  (divisor_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            short_q    <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            short_q    <= short_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
        end
    end

    // Next-state: accept in idle, iterate in run, finish with a one-cycle done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        result_d   = result_q;
        short_d    = short_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    rem_d      = '0;
                    cnt_d      = '0;
                    dbz_d      = 1'b0;
                    short_d    = start_short;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (short_q) begin
                    // Remainder is the dividend itself; flag a zero divisor.
                    result_d = dividend_q;
                    dbz_d    = (divisor_q == '0);
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    rem_d      = rem_next;
                    // Consumed dividend bits leave the top; quotient bits fill the bottom.
                    dividend_d = {dividend_q[WIDTH-2:0], q_bit};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        result_d = rem_next;
                        done_d   = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q == StRun);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_modulud.sv
// tb_modulud: scoreboard bench for the modulud remainder unit.
module tb_modulud;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] rem;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    modulud #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return 1;
`ifdef MODULUD_EARLY_EXIT_EN
        if (a < b) return 1;
`endif
        return W;
    endfunction

    // Drive one start, push the expectation at the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e.rem = (b == '0) ? a : a % b;
        e.dbz = (b == '0);
        e.lat = exp_lat(a, b);
        e.acc = cyc;
        sb.push_back(e);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) until the scoreboard drains.
    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b);
        wait_done();
    endtask

    // Pop and compare whenever the DUT signals completion.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", {16'd0, result}, {16'd0, e.rem});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                check("latency", cyc - e.acc, e.lat);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'd52, 16'd50);
        @(posedge clk);
        #2;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        run_op(16'd500, 16'd400);
        run_op(16'd14583, 16'd8928);
        run_op(16'd65535, 16'd65535);
        run_op(16'd1234, 16'd0);
        run_op(16'd1000, 16'd3);
        run_op(16'd7, 16'd9);
        run_op(16'd65535, 16'd32768);

        // Abort mid-run with reset; a later operation must still be correct.
        issue(16'd1000, 16'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        check("midrun_rst_done", {31'd0, done}, 32'd0);
        check("midrun_rst_result", {16'd0, result}, 32'd0);
        sb.delete();
        rst_n = 1'b1;
        run_op(16'd1000, 16'd7);

        // Start held high with changing operands while busy is ignored.
        issue(16'd300, 16'd7);
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dividend = 16'($urandom);
            divisor  = 16'(i + 1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done();

        // Back-to-back: start issued in the done cycle.
        issue(16'd52, 16'd50);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("b2b_first_done", {31'd0, done}, 32'd1);
        issue(16'd500, 16'd400);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(1, 65535)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
